// File: rtl/sniffer_pkg.sv
// Shared widths and helpers for the multi-port sniffer: packet/port-id width
// derivation, {tag, resp, data} packing and saturating counter increment.
package sniffer_pkg;

    // Helpers work on a wide carrier so they stay parameter-agnostic; callers
    // zero-extend their arguments and size-cast the result back down.
    localparam int MAX_W = 128;

    function automatic int calc_pkt_w(input int tag_w, input int resp_w, input int data_w);
        return tag_w + resp_w + data_w;
    endfunction

    function automatic int calc_pid_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic logic [MAX_W-1:0] pack_pkt(input logic [MAX_W-1:0] tag,
                                                  input logic [MAX_W-1:0] resp,
                                                  input logic [MAX_W-1:0] data,
                                                  input int resp_w,
                                                  input int data_w);
        return (tag << (resp_w + data_w)) | (resp << data_w) | data;
    endfunction

    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] cnt, input int cnt_w);
        logic [MAX_W-1:0] cnt_max;
        cnt_max = (MAX_W'(1) << cnt_w) - MAX_W'(1);
        return (cnt >= cnt_max) ? cnt : cnt + MAX_W'(1);
    endfunction

endpackage

// File: rtl/sniffer_fifo.sv
// Single-clock synchronous FIFO with a wrap-bit pointer scheme; head shows the
// oldest entry whenever empty is low.
module sniffer_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Same address with opposite wrap bits means the writer lapped the reader.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/sniffer_arb_mux.sv
// Captures per-port {tag, resp, data} packets into per-port FIFOs and merges
// them round-robin onto one registered stream tagged with the source port.
//
// Output handshake: a packet transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_packet and out_port_id hold steady and no FIFO is popped.
module sniffer_arb_mux
    import sniffer_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int RESP_W     = 2,
    parameter int TAG_W      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int PKT_W     = calc_pkt_w(TAG_W, RESP_W, DATA_W),
    localparam int PID_W     = calc_pid_w(NUM_PORTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    input  logic [NUM_PORTS*RESP_W-1:0] in_resp,
    input  logic [NUM_PORTS*TAG_W-1:0] in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PID_W-1:0]           out_port_id,
    output logic [PKT_W-1:0]           out_packet,
    output logic [NUM_PORTS-1:0]       fifo_full,
    output logic [NUM_PORTS*CNT_W-1:0] drop_count,
    input  logic                       drop_clr
);

    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] empty;
    logic [PKT_W-1:0]     head [NUM_PORTS];

    logic [PID_W-1:0] rr_ptr;
    logic [PID_W-1:0] grant_idx;
    logic [PID_W-1:0] next_ptr;
    logic             grant_valid;
    logic             load;

    assign load = !out_valid || out_ready;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [PKT_W-1:0] pkt;
        logic [CNT_W-1:0] cnt;

        assign pkt = PKT_W'(pack_pkt(MAX_W'(in_tag[i*TAG_W +: TAG_W]),
                                     MAX_W'(in_resp[i*RESP_W +: RESP_W]),
                                     MAX_W'(in_data[i*DATA_W +: DATA_W]),
                                     RESP_W, DATA_W));

        // Full is the pre-edge flag, so a pop in the same cycle cannot rescue a push.
        assign push[i] = in_valid[i] && !fifo_full[i];
        assign pop[i]  = load && grant_valid && (grant_idx == PID_W'(i));

        sniffer_fifo #(
            .WIDTH (PKT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push[i]),
            .wr_data (pkt),
            .pop     (pop[i]),
            .full    (fifo_full[i]),
            .empty   (empty[i]),
            .head    (head[i])
        );

        // Clear wins over a coincident drop.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt <= '0;
            else if (drop_clr)
                cnt <= '0;
            else if (in_valid[i] && fifo_full[i])
                cnt <= CNT_W'(sat_inc(MAX_W'(cnt), CNT_W));
        end

        assign drop_count[i*CNT_W +: CNT_W] = cnt;
    end

    // Round-robin search starting at rr_ptr, which points one past the last grant.
    always_comb begin
        logic [PID_W-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = PID_W'((int'(rr_ptr) + k) % NUM_PORTS);
            if (!grant_valid && !empty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    assign next_ptr = (grant_idx == PID_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_packet  <= '0;
            out_port_id <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_packet  <= head[grant_idx];
                out_port_id <= grant_idx;
                rr_ptr      <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_sniffer_arb_mux.sv
// Bench for sniffer_arb_mux: directed scenarios plus random traffic, checked
// against a queue-based model of per-port buffers, output register and drops.
module tb_sniffer_arb_mux;

    localparam int NP      = 4;
    localparam int DW      = 32;
    localparam int RW      = 2;
    localparam int TW      = 2;
    localparam int DEPTH   = 4;
    localparam int CW      = 4;
    localparam int PKT_W   = TW + RW + DW;
    localparam int PID_W   = 2;
    localparam int SB_W    = PID_W + PKT_W;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NP-1:0]        in_valid;
    logic [NP*DW-1:0]     in_data;
    logic [NP*RW-1:0]     in_resp;
    logic [NP*TW-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [PID_W-1:0]     out_port_id;
    logic [PKT_W-1:0]     out_packet;
    logic [NP-1:0]        fifo_full;
    logic [NP*CW-1:0]     drop_count;
    logic                 drop_clr;

    sniffer_arb_mux #(
        .NUM_PORTS  (NP),
        .DATA_W     (DW),
        .RESP_W     (RW),
        .TAG_W      (TW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_resp     (in_resp),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_port_id (out_port_id),
        .out_packet  (out_packet),
        .fifo_full   (fifo_full),
        .drop_count  (drop_count),
        .drop_clr    (drop_clr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model and scoreboard ----------------
    logic [PKT_W-1:0] mq [NP][$];
    logic             m_valid;
    logic [PKT_W-1:0] m_pkt;
    int               m_pid;
    int               m_ptr;
    int               m_cnt [NP];
    logic [SB_W-1:0]  exp_q [$];
    int               checks = 0;
    int               passes = 0;

    function automatic logic [NP-1:0] exp_full();
        logic [NP-1:0] f;
        for (int i = 0; i < NP; i++) f[i] = (mq[i].size() == DEPTH);
        return f;
    endfunction

    function automatic logic [NP*CW-1:0] exp_drops();
        logic [NP*CW-1:0] d;
        for (int i = 0; i < NP; i++) d[i*CW +: CW] = CW'(m_cnt[i]);
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            m_cnt[i] = 0;
        end
        m_valid = 1'b0;
        m_pkt   = '0;
        m_pid   = 0;
        m_ptr   = 0;
    endtask

    // One rising edge: output side uses pre-edge buffer contents, then captures.
    task automatic model_step();
        logic [NP-1:0] full_pre;
        int g;
        int p;
        full_pre = exp_full();
        if (!m_valid || out_ready) begin
            g = -1;
            for (int k = 0; k < NP; k++) begin
                p = (m_ptr + k) % NP;
                if (g < 0 && mq[p].size() > 0) g = p;
            end
            if (g >= 0) begin
                m_pkt   = mq[g].pop_front();
                m_pid   = g;
                m_valid = 1'b1;
                m_ptr   = (g + 1) % NP;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (in_valid[i]) begin
                if (full_pre[i]) begin
                    if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
                end else begin
                    mq[i].push_back({in_tag[i*TW +: TW], in_resp[i*RW +: RW], in_data[i*DW +: DW]});
                end
            end
        end
        if (drop_clr)
            for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        in_valid = '0;
        in_data  = '0;
        in_resp  = '0;
        in_tag   = '0;
        drop_clr = 1'b0;
    endtask

    task automatic set_port(input int p, input logic [TW-1:0] t, input logic [RW-1:0] r,
                            input logic [DW-1:0] d);
        in_valid[p]          = 1'b1;
        in_tag[p*TW +: TW]   = t;
        in_resp[p*RW +: RW]  = r;
        in_data[p*DW +: DW]  = d;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive_idle();
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if ({out_valid, out_port_id, out_packet, fifo_full, drop_count} !== '0)
            $display("FAIL reset_state: got v=%b id=%0d pkt=%h full=%b drops=%h, want all zero",
                     out_valid, out_port_id, out_packet, fifo_full, drop_count);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin
            step();
            checks++;
            if ({out_valid, out_port_id, out_packet} !== {m_valid, PID_W'(m_pid), m_pkt})
                $display("FAIL reset_idle_out: got v=%b id=%0d pkt=%h, want v=%b id=%0d pkt=%h",
                         out_valid, out_port_id, out_packet, m_valid, m_pid, m_pkt);
            else passes++;
        end
    endtask

    task automatic test_single_capture();
        out_ready = 1'b1;
        set_port(2, 2'b11, 2'b01, 32'hDEADBEEF);
        exp_q.push_back({2'd2, 36'hDDEADBEEF});
        step();
        drive_idle();
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL single_early: got v=%b, want v=0", out_valid);
        else passes++;
        step();
        checks++;
        if ({out_valid, out_port_id, out_packet} !== {1'b1, exp_q[0]})
            $display("FAIL single_capture: got v=%b id=%0d pkt=%h, want v=1 id/pkt=%h",
                     out_valid, out_port_id, out_packet, exp_q[0]);
        else passes++;
        void'(exp_q.pop_front());
        step();
        checks++;
        if ({out_valid, out_port_id, out_packet} !== {m_valid, PID_W'(m_pid), m_pkt})
            $display("FAIL single_after: got v=%b id=%0d pkt=%h, want v=%b id=%0d pkt=%h",
                     out_valid, out_port_id, out_packet, m_valid, m_pid, m_pkt);
        else passes++;
    endtask

    task automatic test_round_robin();
        apply_reset();
        out_ready = 1'b1;
        for (int burst = 0; burst < 2; burst++) begin
            for (int p = 0; p < NP; p++) begin
                if (burst == 0 || p == 0 || p == 3) begin
                    set_port(p, '0, '0, DW'(burst * 16 + p));
                    exp_q.push_back({PID_W'(p), PKT_W'(burst * 16 + p)});
                end
            end
            step();
            drive_idle();
            for (int c = 0; c < 8; c++) begin
                if (out_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0 || {out_port_id, out_packet} !== exp_q[0])
                        $display("FAIL rr_order: got id=%0d pkt=%h, want %h (queue %0d)",
                                 out_port_id, out_packet, (exp_q.size() > 0) ? exp_q[0] : '0, exp_q.size());
                    else passes++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                step();
                checks++;
                if ({out_valid, out_port_id, out_packet} !== {m_valid, PID_W'(m_pid), m_pkt})
                    $display("FAIL rr_model: got v=%b id=%0d pkt=%h, want v=%b id=%0d pkt=%h",
                             out_valid, out_port_id, out_packet, m_valid, m_pid, m_pkt);
                else passes++;
            end
            checks++;
            if (exp_q.size() != 0)
                $display("FAIL rr_missing: got %0d packets outstanding, want 0", exp_q.size());
            else passes++;
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_idle();
            set_port(1, '0, '0, DW'(100 + k));
            step();
            checks++;
            if ({fifo_full, drop_count} !== {exp_full(), exp_drops()})
                $display("FAIL ovf_status: got full=%b drops=%h, want full=%b drops=%h",
                         fifo_full, drop_count, exp_full(), exp_drops());
            else passes++;
        end
        drive_idle();
        checks++;
        if (drop_count[1*CW +: CW] !== CW'(1))
            $display("FAIL ovf_drop1: got %0d, want 1", drop_count[1*CW +: CW]);
        else passes++;
        checks++;
        if (fifo_full !== 4'b0010)
            $display("FAIL ovf_full: got %b, want 0010", fifo_full);
        else passes++;
        for (int k = 0; k < 5; k++) exp_q.push_back({PID_W'(1), PKT_W'(100 + k)});
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || {out_port_id, out_packet} !== exp_q[0])
                    $display("FAIL ovf_drain: got id=%0d pkt=%h, want %h (queue %0d)",
                             out_port_id, out_packet, (exp_q.size() > 0) ? exp_q[0] : '0, exp_q.size());
                else passes++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            step();
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL ovf_missing: got %0d outstanding v=%b, want 0 v=0", exp_q.size(), out_valid);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic [PKT_W-1:0] hold_pkt;
        logic [PID_W-1:0] hold_id;
        logic [NP-1:0]    hold_full;
        apply_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_idle();
            for (int p = 0; p < NP; p++)
                set_port(p, TW'($urandom), RW'($urandom), DW'($urandom));
            step();
        end
        drive_idle();
        step();
        hold_pkt  = m_pkt;
        hold_id   = PID_W'(m_pid);
        hold_full = exp_full();
        checks++;
        if ({out_valid, out_port_id, out_packet} !== {1'b1, hold_id, hold_pkt})
            $display("FAIL bp_start: got v=%b id=%0d pkt=%h, want v=1 id=%0d pkt=%h",
                     out_valid, out_port_id, out_packet, hold_id, hold_pkt);
        else passes++;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({out_valid, out_port_id, out_packet, fifo_full} !== {1'b1, hold_id, hold_pkt, hold_full})
                $display("FAIL bp_hold: got v=%b id=%0d pkt=%h full=%b, want v=1 id=%0d pkt=%h full=%b",
                         out_valid, out_port_id, out_packet, fifo_full, hold_id, hold_pkt, hold_full);
            else passes++;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            checks++;
            if ({out_valid, out_port_id, out_packet, fifo_full} !== {m_valid, PID_W'(m_pid), m_pkt, exp_full()})
                $display("FAIL bp_drain: got v=%b id=%0d pkt=%h full=%b, want v=%b id=%0d pkt=%h full=%b",
                         out_valid, out_port_id, out_packet, fifo_full, m_valid, m_pid, m_pkt, exp_full());
            else passes++;
        end
    endtask

    task automatic test_drop_sat();
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 26; k++) begin
            drive_idle();
            set_port(0, TW'($urandom), RW'($urandom), DW'($urandom));
            step();
            checks++;
            if ({fifo_full, drop_count} !== {exp_full(), exp_drops()})
                $display("FAIL sat_status: got full=%b drops=%h, want full=%b drops=%h",
                         fifo_full, drop_count, exp_full(), exp_drops());
            else passes++;
        end
        checks++;
        if (drop_count[CW-1:0] !== CW'(15))
            $display("FAIL sat_value: got %0d, want 15", drop_count[CW-1:0]);
        else passes++;
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        checks++;
        if (drop_count !== '0)
            $display("FAIL sat_clr_wins: got %h, want 0", drop_count);
        else passes++;
        step();
        checks++;
        if (drop_count[CW-1:0] !== CW'(1))
            $display("FAIL sat_after_clr: got %0d, want 1", drop_count[CW-1:0]);
        else passes++;
        drive_idle();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 1) == 1)
                    set_port(p, TW'($urandom), RW'($urandom), DW'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            drop_clr  = ($urandom_range(0, 31) == 0);
            step();
            checks++;
            if ({out_valid, out_port_id, out_packet} !== {m_valid, PID_W'(m_pid), m_pkt})
                $display("FAIL rand_out @%0d: got v=%b id=%0d pkt=%h, want v=%b id=%0d pkt=%h",
                         c, out_valid, out_port_id, out_packet, m_valid, m_pid, m_pkt);
            else passes++;
            checks++;
            if ({fifo_full, drop_count} !== {exp_full(), exp_drops()})
                $display("FAIL rand_status @%0d: got full=%b drops=%h, want full=%b drops=%h",
                         c, fifo_full, drop_count, exp_full(), exp_drops());
            else passes++;
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive_idle();
            set_port(0, TW'($urandom), RW'($urandom), DW'($urandom));
            if (k % 2 == 0) set_port(2, TW'($urandom), RW'($urandom), DW'($urandom));
            step();
        end
        checks++;
        if ({out_valid, fifo_full[0], drop_count[CW-1:0]} !== {1'b1, 1'b1, CW'(m_cnt[0])})
            $display("FAIL arst_pre: got v=%b full0=%b drop0=%0d, want v=1 full0=1 drop0=%0d",
                     out_valid, fifo_full[0], drop_count[CW-1:0], m_cnt[0]);
        else passes++;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({out_valid, out_port_id, out_packet, fifo_full, drop_count} !== '0)
            $display("FAIL arst_immediate: got v=%b id=%0d pkt=%h full=%b drops=%h, want all zero",
                     out_valid, out_port_id, out_packet, fifo_full, drop_count);
        else passes++;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if ({out_valid, out_port_id, out_packet, fifo_full} !== {m_valid, PID_W'(m_pid), m_pkt, exp_full()})
                $display("FAIL arst_stale: got v=%b id=%0d pkt=%h full=%b, want v=%b id=%0d pkt=%h full=%b",
                         out_valid, out_port_id, out_packet, fifo_full, m_valid, m_pid, m_pkt, exp_full());
            else passes++;
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_single_capture();
        test_round_robin();
        test_overflow();
        test_backpressure();
        test_drop_sat();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
